// File: rtl/genius_control_fsm_if.sv
// rtl/genius_control_fsm_if.sv - Datapath status/control bundle between controller and datapath
interface genius_control_fsm_if;
    logic end_FPGA_i;
    logic end_User_i;
    logic end_time_i;
    logic win_i;
    logic match_i;
    logic R1_o;
    logic R2_o;
    logic E1_o;
    logic E2_o;
    logic E3_o;
    logic E4_o;
    logic SEL_o;

    modport master (
        input  end_FPGA_i, end_User_i, end_time_i, win_i, match_i,
        output R1_o, R2_o, E1_o, E2_o, E3_o, E4_o, SEL_o
    );

    modport slave (
        output end_FPGA_i, end_User_i, end_time_i, win_i, match_i,
        input  R1_o, R2_o, E1_o, E2_o, E3_o, E4_o, SEL_o
    );
endinterface

// File: rtl/genius_control_fsm.sv
// rtl/genius_control_fsm.sv - Genius game controller with ENTER synchroniser and press pulse
module genius_control_fsm #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_i,
    input  logic                 enter_n_i,
    genius_control_fsm_if.master dp,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        SETUP      = 3'd1,
        PLAY_FPGA  = 3'd2,
        PLAY_USER  = 3'd3,
        CHECK      = 3'd4,
        NEXT_ROUND = 3'd5,
        RESULT     = 3'd6,
        ILLEGAL    = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic                   enter_p;
    logic r1_q, r2_q, e1_q, e2_q, e3_q, e4_q, sel_q;
    logic r1_d, r2_d, e1_d, e2_d, e3_d, e4_d, sel_d;

    // Press is the 1->0 edge of the synchronised key, so holding it yields one pulse.
    assign enter_p = dly_q & ~sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], enter_n_i};
        dly_d   = sync_q[SYNC_STAGES-1];
        state_d = state_q;
        case (state_q)
            INIT:       state_d = SETUP;
            SETUP:      if (enter_p) state_d = PLAY_FPGA;
            PLAY_FPGA:  if (dp.end_FPGA_i) state_d = PLAY_USER;
            PLAY_USER: begin
                if (dp.end_User_i)      state_d = CHECK;
                else if (dp.end_time_i) state_d = RESULT;
            end
            CHECK: begin
                if (!dp.match_i || dp.win_i) state_d = RESULT;
                else                         state_d = NEXT_ROUND;
            end
            NEXT_ROUND: state_d = PLAY_FPGA;
            RESULT:     if (enter_p) state_d = INIT;
            default:    state_d = INIT;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they stay aligned with state_q.
    always_comb begin
        r1_d  = 1'b0;
        r2_d  = 1'b0;
        e1_d  = 1'b0;
        e2_d  = 1'b0;
        e3_d  = 1'b0;
        e4_d  = 1'b0;
        sel_d = 1'b0;
        case (state_d)
            INIT: begin
                r1_d = 1'b1;
                r2_d = 1'b1;
            end
            SETUP:      e1_d = 1'b1;
            PLAY_FPGA:  e3_d = 1'b1;
            PLAY_USER:  e2_d = 1'b1;
            NEXT_ROUND: begin
                e4_d = 1'b1;
                r2_d = 1'b1;
            end
            RESULT:     sel_d = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_i) begin
            state_q <= INIT;
            sync_q  <= '1;
            dly_q   <= 1'b1;
            r1_q    <= 1'b1;
            r2_q    <= 1'b1;
            e1_q    <= 1'b0;
            e2_q    <= 1'b0;
            e3_q    <= 1'b0;
            e4_q    <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            dly_q   <= dly_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            e3_q    <= e3_d;
            e4_q    <= e4_d;
            sel_q   <= sel_d;
        end
    end

    assign state_o  = state_q;
    assign dp.R1_o  = r1_q;
    assign dp.R2_o  = r2_q;
    assign dp.E1_o  = e1_q;
    assign dp.E2_o  = e2_q;
    assign dp.E3_o  = e3_q;
    assign dp.E4_o  = e4_q;
    assign dp.SEL_o = sel_q;

endmodule

// File: tb/tb_genius_control_fsm.sv
// tb/tb_genius_control_fsm.sv - Directed self-checking bench for genius_control_fsm
module tb_genius_control_fsm;

    logic       clock = 1'b0;
    logic       reset_i;
    logic       enter_n_i;
    logic [2:0] state_o;
    int         tests = 0;
    int         failed = 0;

    genius_control_fsm_if dp_if ();

    genius_control_fsm #(.SYNC_STAGES(2)) dut (
        .clock     (clock),
        .reset_i   (reset_i),
        .enter_n_i (enter_n_i),
        .dp        (dp_if.master),
        .state_o   (state_o)
    );

    always #5 clock = ~clock;

    // Outputs packed as {R1,R2,E1,E2,E3,E4,SEL}
    localparam logic [6:0] O_INIT  = 7'b1100000;
    localparam logic [6:0] O_SETUP = 7'b0010000;
    localparam logic [6:0] O_USER  = 7'b0001000;
    localparam logic [6:0] O_FPGA  = 7'b0000100;
    localparam logic [6:0] O_NEXT  = 7'b0100010;
    localparam logic [6:0] O_RES   = 7'b0000001;
    localparam logic [6:0] O_NONE  = 7'b0000000;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic check(input string tag, input logic [2:0] exp_state, input logic [6:0] exp_outs);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {state_o, dp_if.R1_o, dp_if.R2_o, dp_if.E1_o, dp_if.E2_o,
               dp_if.E3_o, dp_if.E4_o, dp_if.SEL_o};
        exp = {exp_state, exp_outs};
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed state=%0d outs=%b, expected state=%0d outs=%b",
                   tag, obs[9:7], obs[6:0], exp[9:7], exp[6:0]);
        end
    endtask

    // Press from SETUP or RESULT: transition on edge 3, then release and let the synchroniser settle.
    task automatic press();
        enter_n_i = 1'b0;
        step(3);
        enter_n_i = 1'b1;
        step(2);
    endtask

    initial begin
        reset_i          = 1'b1;
        enter_n_i        = 1'b1;
        dp_if.end_FPGA_i = 1'b0;
        dp_if.end_User_i = 1'b0;
        dp_if.end_time_i = 1'b0;
        dp_if.win_i      = 1'b0;
        dp_if.match_i    = 1'b0;
        @(negedge clock);
        step(2);
        check("reset_state", 3'd0, O_INIT);

        reset_i = 1'b0;
        step(1);
        check("setup_entry", 3'd1, O_SETUP);
        dp_if.end_FPGA_i = 1'b1;
        step(3);
        dp_if.end_FPGA_i = 1'b0;
        check("setup_no_press_hold", 3'd1, O_SETUP);

        enter_n_i = 1'b0;
        step(2);
        check("press_edge2", 3'd1, O_SETUP);
        step(1);
        check("press_edge3", 3'd2, O_FPGA);
        step(17);
        check("press_held_20", 3'd2, O_FPGA);
        enter_n_i = 1'b1;
        step(2);

        dp_if.end_FPGA_i = 1'b1;
        step(1);
        dp_if.end_FPGA_i = 1'b0;
        check("round_user", 3'd3, O_USER);
        dp_if.end_User_i = 1'b1;
        dp_if.match_i    = 1'b1;
        dp_if.win_i      = 1'b0;
        step(1);
        dp_if.end_User_i = 1'b0;
        check("round_check", 3'd4, O_NONE);
        step(1);
        check("round_next", 3'd5, O_NEXT);
        step(1);
        check("round_back_fpga", 3'd2, O_FPGA);

        dp_if.end_FPGA_i = 1'b1;
        step(1);
        dp_if.end_FPGA_i = 1'b0;
        dp_if.end_time_i = 1'b1;
        step(1);
        dp_if.end_time_i = 1'b0;
        check("timeout_result", 3'd6, O_RES);
        step(3);
        check("result_holds", 3'd6, O_RES);

        enter_n_i = 1'b0;
        step(3);
        check("result_press_init", 3'd0, O_INIT);
        step(1);
        check("result_to_setup", 3'd1, O_SETUP);
        step(4);
        check("held_press_no_repulse", 3'd1, O_SETUP);
        enter_n_i = 1'b1;
        step(2);
        press();
        check("second_press_fpga", 3'd2, O_FPGA);

        dp_if.end_FPGA_i = 1'b1;
        step(1);
        dp_if.end_FPGA_i = 1'b0;
        dp_if.end_User_i = 1'b1;
        dp_if.end_time_i = 1'b1;
        dp_if.match_i    = 1'b0;
        step(1);
        dp_if.end_User_i = 1'b0;
        dp_if.end_time_i = 1'b0;
        check("user_beats_time", 3'd4, O_NONE);
        step(1);
        check("mismatch_lose", 3'd6, O_RES);

        press();
        check("lose_restart_setup", 3'd1, O_SETUP);
        press();
        dp_if.end_FPGA_i = 1'b1;
        step(1);
        dp_if.end_FPGA_i = 1'b0;
        dp_if.end_User_i = 1'b1;
        dp_if.match_i    = 1'b1;
        dp_if.win_i      = 1'b1;
        step(1);
        dp_if.end_User_i = 1'b0;
        check("win_check", 3'd4, O_NONE);
        step(1);
        dp_if.win_i = 1'b0;
        check("win_result", 3'd6, O_RES);
        press();
        check("win_restart_setup", 3'd1, O_SETUP);

        press();
        dp_if.end_FPGA_i = 1'b1;
        step(1);
        dp_if.end_FPGA_i = 1'b0;
        check("midround_user", 3'd3, O_USER);
        enter_n_i = 1'b0;
        reset_i   = 1'b1;
        step(1);
        check("midround_reset", 3'd0, O_INIT);
        reset_i   = 1'b0;
        enter_n_i = 1'b1;
        step(1);
        check("post_reset_setup", 3'd1, O_SETUP);
        step(4);
        check("post_reset_no_pulse", 3'd1, O_SETUP);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
